// File: rtl/udma_eth_tx_controller.sv
// udma_eth_tx_controller
// Transmit-side controller for the uDMA Ethernet peripheral. Frame lengths
// queued by software are popped one at a time. Each one arms the uDMA TX
// channel for that many bytes. The bytes are then forwarded from the TX
// buffer onto an AXI-Stream master toward the MAC, with TLAST on the final
// byte.
//
// Build option: define UDMA_ETH_TX_PAD_EN to extend short frames (< 60 bytes)
// to 60 bytes with internally generated 0x00 pad bytes.
module udma_eth_tx_controller #(
    parameter int unsigned L2_AWIDTH_NOAL  = 12,
    parameter int unsigned TRANS_SIZE      = 16,
    parameter int unsigned LEN_QUEUE_DEPTH = 4,
    parameter int unsigned MAX_FRAME_LEN   = 1518
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_i,

    input  logic [L2_AWIDTH_NOAL-1:0] reg_tx_startaddr_i,
    input  logic [10:0]               reg_tx_len_i,
    input  logic                      reg_tx_push_i,
    output logic                      reg_tx_queue_full_o,
    output logic                      reg_tx_busy_o,

    output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [1:0]                cfg_tx_datasize_o,
    output logic                      cfg_tx_en_o,

    input  logic [7:0]                tx_buffer_data_i,
    input  logic                      tx_buffer_valid_i,
    output logic                      tx_buffer_ready_o,

    output logic [7:0]                m_axis_tdata_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tlast_o,
    input  logic                      m_axis_tready_i,

    output logic                      eth_tx_event_o,
    output logic                      eth_error_event_o
);

    localparam int unsigned QAW     = $clog2(LEN_QUEUE_DEPTH);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
`ifdef UDMA_ETH_TX_PAD_EN
    localparam logic [10:0] MIN_LEN = 11'd60;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Frame-length queue
    // ------------------------------------------------------------------
    logic [10:0]    q_mem [LEN_QUEUE_DEPTH];
    logic [QAW-1:0] q_wr_ptr;
    logic [QAW-1:0] q_rd_ptr;
    logic [QAW:0]   q_count;
    logic           q_empty;
    logic           q_full;
    logic           q_pop;
    logic           q_push_ok;
    logic           q_overflow;
    logic [10:0]    q_head;

    assign q_empty    = (q_count == '0);
    assign q_full     = (q_count == (QAW+1)'(LEN_QUEUE_DEPTH));
    assign q_head     = q_mem[q_rd_ptr];
    // A push into a full queue is still accepted when the head leaves in
    // the same cycle.
    assign q_push_ok  = reg_tx_push_i && (!q_full || q_pop);
    assign q_overflow = reg_tx_push_i && q_full && !q_pop;

    // Queue storage: written on accepted pushes only.
    always_ff @(posedge sys_clk_i) begin
        if (q_push_ok) begin
            q_mem[q_wr_ptr] <= reg_tx_len_i;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (q_push_ok) begin
                q_wr_ptr <= q_wr_ptr + 1'b1;
            end
            if (q_pop) begin
                q_rd_ptr <= q_rd_ptr + 1'b1;
            end
            case ({q_push_ok, q_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Streaming datapath signals
    // ------------------------------------------------------------------
    logic [10:0] frame_len;
    logic [10:0] emit_len;
    logic [10:0] loaded;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        load_slot;
    logic        buf_ready;
    logic        buf_take;
    logic        pad_take;
    logic        load;
    logic        start;
    logic        bad_len;
    logic        cfg_en;
    logic        err;
    logic [TRANS_SIZE-1:0] cfg_size;

    // The output register can take a new byte when empty or draining now.
    assign load_slot = !out_valid || m_axis_tready_i;
    assign buf_ready = (state == STREAM) && load_slot && (loaded < frame_len);
    assign buf_take  = buf_ready && tx_buffer_valid_i;

`ifdef UDMA_ETH_TX_PAD_EN
    // Pad bytes are produced only after every buffer byte has been loaded.
    assign emit_len  = (frame_len < MIN_LEN) ? MIN_LEN : frame_len;
    assign pad_take  = (state == STREAM) && load_slot &&
                       (loaded >= frame_len) && (loaded < emit_len);
`else
    assign emit_len  = frame_len;
    assign pad_take  = 1'b0;
`endif

    assign load = buf_take || pad_take;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, queue pop and frame start/reject decisions.
    always_comb begin
        state_next = state;
        q_pop      = 1'b0;
        start      = 1'b0;
        bad_len    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!q_empty) begin
                    q_pop = 1'b1;
                    if ((q_head == 11'd0) || (q_head > MAX_LEN)) begin
                        bad_len = 1'b1;
                    end else begin
                        start      = 1'b1;
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                if (out_valid && m_axis_tready_i && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame length latch, uDMA programming pulse and error pulse.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            frame_len <= '0;
            cfg_size  <= '0;
            cfg_en    <= 1'b0;
            err       <= 1'b0;
        end else begin
            cfg_en <= start;
            err    <= q_overflow || bad_len;
            if (start) begin
                frame_len <= q_head;
                cfg_size  <= TRANS_SIZE'(q_head);
            end
        end
    end

    // Byte counter and AXI-Stream output register.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            loaded    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (start) begin
                loaded <= '0;
            end else if (load) begin
                loaded <= loaded + 11'd1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= buf_take ? tx_buffer_data_i : 8'h00;
                out_last  <= (loaded == emit_len - 11'd1);
            end else if (m_axis_tready_i) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign reg_tx_queue_full_o = q_full;
    assign reg_tx_busy_o       = (state != IDLE) || !q_empty;
    assign cfg_tx_startaddr_o  = reg_tx_startaddr_i;
    assign cfg_tx_size_o       = cfg_size;
    assign cfg_tx_datasize_o   = 2'b00;
    assign cfg_tx_en_o         = cfg_en;
    assign tx_buffer_ready_o   = buf_ready;
    assign m_axis_tdata_o      = out_data;
    assign m_axis_tvalid_o     = out_valid;
    assign m_axis_tlast_o      = out_last;
    assign eth_tx_event_o      = (state == DONE);
    assign eth_error_event_o   = err;

endmodule

// File: tb/tb_udma_eth_tx_controller.sv
// tb_udma_eth_tx_controller
// Randomized bench with a queue-based frame model. Each legal length pushed
// becomes an expected frame: its buffer bytes plus any pad bytes, with the
// last flag on the final byte. The buffer side serves exactly that many bytes
// plus a few surplus bytes that must never be fetched.
`timescale 1ns/1ps
module tb_udma_eth_tx_controller;

    localparam int unsigned AW      = 12;
    localparam int unsigned TS      = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAXLEN  = 1518;
    localparam int unsigned SURPLUS = 3;
`ifdef UDMA_ETH_TX_PAD_EN
    localparam int MIN_EMIT = 60;
`else
    localparam int MIN_EMIT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] reg_tx_startaddr;
    logic [10:0]   reg_tx_len;
    logic          reg_tx_push;
    logic          reg_tx_queue_full;
    logic          reg_tx_busy;
    logic [AW-1:0] cfg_tx_startaddr;
    logic [TS-1:0] cfg_tx_size;
    logic [1:0]    cfg_tx_datasize;
    logic          cfg_tx_en;
    logic [7:0]    tx_buffer_data;
    logic          tx_buffer_valid;
    logic          tx_buffer_ready;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          eth_tx_event;
    logic          eth_error_event;

    udma_eth_tx_controller #(
        .L2_AWIDTH_NOAL  (AW),
        .TRANS_SIZE      (TS),
        .LEN_QUEUE_DEPTH (DEPTH),
        .MAX_FRAME_LEN   (MAXLEN)
    ) dut (
        .sys_clk_i           (clk),
        .sys_rst_i           (rst),
        .reg_tx_startaddr_i  (reg_tx_startaddr),
        .reg_tx_len_i        (reg_tx_len),
        .reg_tx_push_i       (reg_tx_push),
        .reg_tx_queue_full_o (reg_tx_queue_full),
        .reg_tx_busy_o       (reg_tx_busy),
        .cfg_tx_startaddr_o  (cfg_tx_startaddr),
        .cfg_tx_size_o       (cfg_tx_size),
        .cfg_tx_datasize_o   (cfg_tx_datasize),
        .cfg_tx_en_o         (cfg_tx_en),
        .tx_buffer_data_i    (tx_buffer_data),
        .tx_buffer_valid_i   (tx_buffer_valid),
        .tx_buffer_ready_o   (tx_buffer_ready),
        .m_axis_tdata_o      (m_axis_tdata),
        .m_axis_tvalid_o     (m_axis_tvalid),
        .m_axis_tlast_o      (m_axis_tlast),
        .m_axis_tready_i     (m_axis_tready),
        .eth_tx_event_o      (eth_tx_event),
        .eth_error_event_o   (eth_error_event)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned valid_pct  = 100;
    int unsigned tready_pct = 100;

    logic [7:0] buf_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] force_q[$];
    int         pend_len[$];

    int ev_cnt = 0, err_cnt = 0, en_cnt = 0;
    int exp_ev = 0, exp_err = 0, exp_en = 0;
    int cyc = 0;
    int cur_len = 0, fr_hs = 0, out_n = 0, first_edge = 0, last_edge = 0;

    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_l = 1'b0;
    logic [7:0] prev_d = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int emit_of(input int len);
        return (len < MIN_EMIT) ? MIN_EMIT : len;
    endfunction

    // Build the expected frame and the buffer contents for a started frame.
    task automatic start_frame(input int len);
        int         emit;
        logic [7:0] b;
        emit    = emit_of(len);
        cur_len = len;
        fr_hs   = 0;
        out_n   = 0;
        for (int i = 0; i < len; i++) begin
            b = (force_q.size() > 0) ? force_q.pop_front() : 8'($urandom);
            buf_q.push_back(b);
            exp_q.push_back({(i == emit - 1), b});
        end
        for (int i = len; i < emit; i++) begin
            exp_q.push_back({(i == emit - 1), 8'h00});
        end
        for (int i = 0; i < int'(SURPLUS); i++) begin
            buf_q.push_back(8'($urandom));
        end
    endtask

    // Sampled once per cycle on the falling edge; handshakes seen here
    // complete at the following rising edge.
    task automatic monitor_cycle();
        int         len;
        logic [8:0] e;
        if (cfg_tx_en) begin
            en_cnt++;
            check_eq("cfg_datasize", 32'(cfg_tx_datasize), 32'd0);
            check_eq("cfg_startaddr", 32'(cfg_tx_startaddr), 32'(reg_tx_startaddr));
            if (pend_len.size() == 0) begin
                check_eq("cfg_en_unexpected", 32'(cfg_tx_en), 32'd0);
            end else begin
                len = pend_len.pop_front();
                check_eq("cfg_size", 32'(cfg_tx_size), len);
                start_frame(len);
            end
        end
        if (tx_buffer_valid && tx_buffer_ready) begin
            if (buf_q.size() > 0) void'(buf_q.pop_front());
            fr_hs++;
        end
        if (prev_v && !prev_r) begin
            check_eq("tvalid_held", 32'(m_axis_tvalid), 32'd1);
            check_eq("tdata_held", 32'(m_axis_tdata), 32'(prev_d));
            check_eq("tlast_held", 32'(m_axis_tlast), 32'(prev_l));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("tvalid_unexpected", 32'(m_axis_tvalid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("tdata", 32'(m_axis_tdata), 32'(e[7:0]));
                check_eq("tlast", 32'(m_axis_tlast), 32'(e[8]));
            end
            if (out_n == 0) first_edge = cyc + 1;
            out_n++;
            last_edge = cyc + 1;
        end
        if (eth_tx_event) begin
            ev_cnt++;
            check_eq("ev_frame_drained", exp_q.size(), 0);
            check_eq("ev_buf_fetches", fr_hs, cur_len);
            check_eq("ev_surplus_untouched", buf_q.size(), SURPLUS);
            check_eq("ev_latency", cyc, last_edge);
            buf_q.delete();
        end
        if (eth_error_event) err_cnt++;
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
    endtask

    // Buffer source, MAC sink and monitor.
    initial begin
        tx_buffer_valid = 1'b0;
        tx_buffer_data  = 8'h00;
        m_axis_tready   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (buf_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                tx_buffer_valid = 1'b1;
                tx_buffer_data  = buf_q[0];
            end else begin
                tx_buffer_valid = 1'b0;
                tx_buffer_data  = 8'($urandom);
            end
            m_axis_tready = ($urandom_range(99) < tready_pct);
            @(negedge clk);
            if (rst) prev_v = 1'b0;
            else     monitor_cycle();
        end
    end

    task automatic do_push(input int unsigned len, input bit drop);
        reg_tx_len  = 11'(len);
        reg_tx_push = 1'b1;
        if (drop || len == 0 || len > MAXLEN) begin
            exp_err++;
        end else begin
            pend_len.push_back(int'(len));
            exp_ev++;
            exp_en++;
        end
        @(posedge clk);
        #1;
        reg_tx_push = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (ev_cnt == exp_ev && err_cnt == exp_err && pend_len.size() == 0 && !reg_tx_busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq("done_in_time", 32'(ok), 32'd1);
    endtask

    function automatic int unsigned rand_len();
        int unsigned r;
        r = $urandom_range(9);
        if (r == 0)      return ($urandom_range(1) == 0) ? 0 : $urandom_range(MAXLEN + 1, 2047);
        else if (r == 1) return $urandom_range(61, 120);
        else             return $urandom_range(1, 64);
    endfunction

    initial begin
        rst              = 1'b1;
        reg_tx_push      = 1'b0;
        reg_tx_len       = '0;
        reg_tx_startaddr = 12'h5A4;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check_eq("rst_cfg_en", 32'(cfg_tx_en), 32'd0);
        check_eq("rst_cfg_size", 32'(cfg_tx_size), 32'd0);
        check_eq("rst_busy", 32'(reg_tx_busy), 32'd0);
        check_eq("rst_full", 32'(reg_tx_queue_full), 32'd0);
        check_eq("rst_ready", 32'(tx_buffer_ready), 32'd0);
        check_eq("rst_events", 32'({eth_tx_event, eth_error_event}), 32'd0);
        check_eq("rst_startaddr", 32'(cfg_tx_startaddr), 32'h5A4);
        reg_tx_startaddr = 12'h3C0;
        #1;
        check_eq("startaddr_follow", 32'(cfg_tx_startaddr), 32'h3C0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Known 4-byte frame at full rate, with cfg latency checks.
        force_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_push(4, 1'b0);
        check_eq("en_latency_early", 32'(cfg_tx_en), 32'd0);
        @(posedge clk);
        #1;
        check_eq("en_latency", 32'(cfg_tx_en), 32'd1);
        check_eq("en_size", 32'(cfg_tx_size), 32'd4);
        @(posedge clk);
        #1;
        check_eq("en_one_cycle", 32'(cfg_tx_en), 32'd0);
        wait_done(300);
        check_eq("full_rate_span", last_edge - first_edge, emit_of(4) - 1);

        // Illegal lengths.
        do_push(0, 1'b0);
        do_push(2000, 1'b0);
        wait_done(50);
        repeat (2) @(posedge clk);
        #1;
        check_eq("illegal_no_en", en_cnt, exp_en);
        check_eq("illegal_errs", err_cnt, exp_err);
        check_eq("illegal_idle", 32'(reg_tx_busy), 32'd0);

        // Queue overflow while the first frame is stalled.
        tready_pct = 0;
        do_push(8, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < int'(DEPTH); i++) do_push($urandom_range(1, 20), 1'b0);
        check_eq("q_full", 32'(reg_tx_queue_full), 32'd1);
        do_push($urandom_range(1, 20), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("overflow_err", err_cnt, exp_err);
        tready_pct = 100;
        wait_done(2000);
        check_eq("q_drained", 32'(reg_tx_queue_full), 32'd0);

        // Short frame, padded or not depending on build.
        do_push(10, 1'b0);
        wait_done(300);
        check_eq("len10_bytes", out_n, emit_of(10));

        // Throttled 64-byte frame.
        valid_pct  = 60;
        tready_pct = 50;
        do_push(64, 1'b0);
        wait_done(3000);
        check_eq("len64_bytes", out_n, emit_of(64));

        // Random lengths and throttling, up to three frames queued at once.
        for (int it = 0; it < 16; it++) begin
            valid_pct  = $urandom_range(40, 100);
            tready_pct = $urandom_range(40, 100);
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) do_push(rand_len(), 1'b0);
            wait_done(5000);
        end

        // Reset during byte 10 of a 20-byte frame.
        valid_pct  = 100;
        tready_pct = 100;
        do_push(20, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (en_cnt == exp_en && out_n >= 10) break;
            @(posedge clk);
            #1;
        end
        check_eq("mid_frame_reached", 32'(out_n >= 10), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_async_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_async_ready", 32'(tx_buffer_ready), 32'd0);
        check_eq("rst_async_busy", 32'(reg_tx_busy), 32'd0);
        #1;
        buf_q.delete();
        exp_q.delete();
        pend_len.delete();
        force_q.delete();
        exp_ev--;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_push(3, 1'b0);
        wait_done(300);
        check_eq("post_rst_bytes", out_n, emit_of(3));

        repeat (5) @(posedge clk);
        #1;
        check_eq("total_events", ev_cnt, exp_ev);
        check_eq("total_errors", err_cnt, exp_err);
        check_eq("total_cfg_en", en_cnt, exp_en);
        check_eq("final_idle", 32'(reg_tx_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got %0d events expected %0d", ev_cnt, exp_ev);
        $fatal(1);
    end

endmodule
